// File: rtl/div_sequencer.sv
// div_sequencer: control FSM for the restoring shift/subtract divider.
// It loads the operands, runs WIDTH rounds of shift / subtract /
// check-restore, and reports busy, done and divide-by-zero.
// Every strobe is a registered decode of the state. The only exception is
// alu_op/q_shift in CHECK, which also follow the live rem_neg flag from
// the datapath.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          divisor_zero,
    input  logic          rem_neg,
    output logic          load,
    output logic          rem_shift,
    output logic [1:0]    alu_op,
    output logic [1:0]    q_shift,
    output logic          busy,
    output logic          done,
    output logic          div0,
    output logic [CW-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    state_t        state_r;
    state_t        next_s;
    logic          load_r;
    logic          rem_shift_r;
    logic          sub_r;
    logic          check_r;
    logic          busy_r;
    logic          done_r;
    logic          div0_r;
    logic [CW-1:0] iter_r;

    // Next-state selection. Unused encodings fall back to IDLE.
    always_comb begin
        next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_LOAD;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (divisor_zero) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_SHIFT;
                end
            end
            S_SHIFT: next_s = S_SUB;
            S_SUB:   next_s = S_CHECK;
            S_CHECK: begin
                if (iter_r == LAST_ITER) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_SHIFT;
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // State register. The strobes are decoded from the next state so each
    // one is a flop that lines up with the cycle of its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            load_r      <= 1'b0;
            rem_shift_r <= 1'b0;
            sub_r       <= 1'b0;
            check_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div0_r      <= 1'b0;
            iter_r      <= '0;
        end else begin
            state_r     <= next_s;
            load_r      <= (next_s == S_LOAD);
            rem_shift_r <= (next_s == S_SHIFT);
            sub_r       <= (next_s == S_SUB);
            check_r     <= (next_s == S_CHECK);
            busy_r      <= (next_s != S_IDLE);
            done_r      <= (next_s == S_DONE);

            // div0 belongs to the operation in flight: it clears on an
            // accepted start and is set when the divisor turns out to be zero.
            if (state_r == S_IDLE && next_s == S_LOAD) begin
                div0_r <= 1'b0;
            end else if (state_r == S_LOAD && next_s == S_DONE) begin
                div0_r <= 1'b1;
            end else begin
                div0_r <= div0_r;
            end

            // The iteration count restarts on entry to LOAD and stays at 0
            // through LOAD. It counts completed shifts, saturating at WIDTH.
            // Otherwise it holds through DONE and IDLE until the next LOAD.
            if (next_s == S_LOAD) begin
                iter_r <= '0;
            end else if (state_r == S_SHIFT && iter_r != LAST_ITER) begin
                iter_r <= iter_r + CW'(1);
            end else begin
                iter_r <= iter_r;
            end
        end
    end

    // Output mapping. In CHECK, a negative remainder selects restore and
    // shifts in 0; otherwise it selects no ALU op and shifts in 1.
    always_comb begin
        load      = load_r;
        rem_shift = rem_shift_r;
        busy      = busy_r;
        done      = done_r;
        div0      = div0_r;
        iter      = iter_r;
        if (check_r) begin
            alu_op  = {1'b0, rem_neg};
            q_shift = {rem_neg, 1'b1};
        end else if (sub_r) begin
            alu_op  = 2'b10;
            q_shift = 2'b00;
        end else begin
            alu_op  = 2'b00;
            q_shift = 2'b00;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer (WIDTH=4).
// The driver issues stimulus at the start of each cycle. It pushes the
// outputs that the latency rules predict for that cycle into a queue, and
// pushes each operation's expected result into a second queue. The monitor
// pops and compares both queues at the falling edge.
module tb_div_sequencer;

    localparam int W  = 4;
    localparam int CW = 6;

    typedef struct packed {
        logic          load;
        logic          rem_shift;
        logic [1:0]    alu_op;
        logic [1:0]    q_shift;
        logic          busy;
        logic          done;
        logic          div0;
        logic [CW-1:0] iter;
    } outv_t;

    typedef struct packed {
        logic          div0;
        logic [CW-1:0] iter;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic          divisor_zero = 1'b0;
    logic          rem_neg = 1'b0;
    logic          load, rem_shift, busy, done, div0;
    logic [1:0]    alu_op, q_shift;
    logic [CW-1:0] iter;

    int compared = 0;
    int mismatched = 0;

    outv_t exp_q[$];
    res_t  res_q[$];

    // Reference model state for the cycle now in progress.
    bit            active = 1'b0;
    int            off = 0;
    bit            zero = 1'b0;
    logic          div0_m = 1'b0;
    logic [CW-1:0] iter_m = '0;

    div_sequencer #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .divisor_zero(divisor_zero),
        .rem_neg(rem_neg), .load(load), .rem_shift(rem_shift),
        .alu_op(alu_op), .q_shift(q_shift), .busy(busy), .done(done),
        .div0(div0), .iter(iter)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Applies one cycle of inputs, predicts this cycle's outputs, and then
    // advances the model across the next rising edge.
    task automatic run_cycle(input logic r, input logic s, input logic dz, input logic rn);
        outv_t e;
        int    endo;
        bit    sub, chk;
        @(posedge clk);
        #1;
        rst = r; start = s; divisor_zero = dz; rem_neg = rn;
        e = '0;
        e.div0 = div0_m;
        e.iter = iter_m;
        if (active) begin
            e.busy = 1'b1;
            e.load = (off == 1);
            if (off == 1) begin
                e.div0 = 1'b0;
                e.iter = '0;
            end else if (zero) begin
                e.done = (off == 2);
                e.div0 = 1'b1;
                e.iter = '0;
            end else begin
                e.div0 = 1'b0;
                e.iter = CW'((off / 3 > W) ? W : off / 3);
                e.rem_shift = (off >= 2 && off <= 3*W-1 && (off-2) % 3 == 0);
                sub = (off >= 3 && off <= 3*W   && (off-3) % 3 == 0);
                chk = (off >= 4 && off <= 3*W+1 && (off-4) % 3 == 0);
                e.alu_op  = sub ? 2'b10 : (chk ? {1'b0, rn} : 2'b00);
                e.q_shift = chk ? {rn, 1'b1} : 2'b00;
                e.done = (off == 3*W+2);
            end
        end
        div0_m = e.div0;
        iter_m = e.iter;
        exp_q.push_back(e);

        endo = zero ? 2 : 3*W+2;
        if (r) begin
            if (active && off >= 2 && off < endo) begin
                void'(res_q.pop_back());
            end
            active = 1'b0;
            div0_m = 1'b0;
            iter_m = '0;
        end else if (active) begin
            if (off >= 2 && off == endo) begin
                active = 1'b0;
            end else begin
                if (off == 1) begin
                    zero = dz;
                    res_q.push_back('{div0: dz, iter: dz ? CW'(0) : CW'(W)});
                end
                off++;
            end
        end else if (s) begin
            active = 1'b1;
            off = 1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: compare the outputs every cycle, and check the result at each done.
    initial begin
        outv_t e, a;
        res_t  r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{load: load, rem_shift: rem_shift, alu_op: alu_op, q_shift: q_shift,
                      busy: busy, done: done, div0: div0, iter: iter};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs t=%0t actual ld=%b rs=%b alu=%b q=%b bsy=%b dn=%b d0=%b it=%0d required ld=%b rs=%b alu=%b q=%b bsy=%b dn=%b d0=%b it=%0d",
                             $time, a.load, a.rem_shift, a.alu_op, a.q_shift, a.busy, a.done, a.div0, a.iter,
                             e.load, e.rem_shift, e.alu_op, e.q_shift, e.busy, e.done, e.div0, e.iter);
                end
                if (done === 1'b1) begin
                    compared++;
                    if (res_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL result t=%0t actual unexpected done required no done", $time);
                    end else begin
                        r = res_q.pop_front();
                        if (div0 !== r.div0 || iter !== r.iter) begin
                            mismatched++;
                            $display("FAIL result t=%0t actual div0=%b iter=%0d required div0=%b iter=%0d",
                                     $time, div0, iter, r.div0, r.iter);
                        end
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        // Reset held for two cycles with start high.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        // Normal divide, rem_neg alternating 0,1,0,1 across the CHECK cycles.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'(((i - 4) / 3) % 2));
        end
        // Divide by zero, then a normal run that clears div0.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(3);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        // start pulses while busy are ignored.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            run_cycle(1'b0, 1'(i == 5 || i == 9), 1'b0, 1'($urandom_range(0, 1)));
        end
        // Reset in the middle of a run, then a full run.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            run_cycle(1'(i == 7), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        // Back-to-back runs with start held high.
        for (int i = 0; i < 50; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        end
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            run_cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(20);
        @(negedge clk);
        #1;
        compared++;
        if (res_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain actual %0d results pending required 0", res_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
